// File: rtl/led_pattern_engine.sv
// led_pattern_engine: multi-mode LED sequencer with a step prescaler
// and pass counting, started and stopped from the control/UI side.
module led_pattern_engine #(
  parameter int N_LEDS = 8,
  parameter int DIV_W  = 24,
  parameter int REPS_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  step_div,
  input  logic [REPS_W-1:0] reps,
  output logic [N_LEDS-1:0] leds,
  output logic              busy,
  output logic              tick,
  output logic              done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [N_LEDS-1:0] LSB1 = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] MSB1 = LSB1 << (N_LEDS-1);
  localparam logic [N_LEDS-1:0] ONES = '1;

  state_t              state_q, state_d;
  logic [N_LEDS-1:0]   leds_d;
  logic                busy_d, tick_d, done_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [REPS_W-1:0]   reps_q, reps_d;
  logic [REPS_W-1:0]   pass_q, pass_d;
  logic [REPS_W-1:0]   pass_inc;
  logic [1:0]          mode_q, mode_d;
  logic                dir_q, dir_d;
  logic [N_LEDS-1:0]   step_pat;
  logic                step_dir;
  logic                pass_end;

  // Next pattern, bounce direction and pass-complete flag for one step.
  // dir_q=0 means the lit bit travels toward the MSB.
  always_comb begin
    step_pat = leds;
    step_dir = dir_q;
    pass_end = 1'b0;
    unique case (mode_q)
      2'd0: begin
        step_pat = {leds[N_LEDS-2:0], leds[N_LEDS-1]};
        pass_end = leds[N_LEDS-1];
      end
      2'd1: begin
        step_pat = {leds[0], leds[N_LEDS-1:1]};
        pass_end = leds[0];
      end
      2'd2: begin
        if (!dir_q) begin
          step_pat = leds << 1;
          step_dir = step_pat[N_LEDS-1];
        end else begin
          step_pat = leds >> 1;
          step_dir = !step_pat[0];
          pass_end = step_pat[0];
        end
      end
      default: begin
        step_pat = ~leds;
        pass_end = (leds == '0);
      end
    endcase
  end

  // Control FSM: load on start, prescale, step, count passes, stop.
  always_comb begin
    state_d  = state_q;
    leds_d   = leds;
    busy_d   = busy;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    div_d    = div_q;
    reps_d   = reps_q;
    mode_d   = mode_q;
    pass_d   = pass_q;
    dir_d    = dir_q;
    pass_inc = pass_q + REPS_W'(1);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          mode_d  = mode;
          reps_d  = reps;
          cnt_d   = '0;
          pass_d  = '0;
          dir_d   = 1'b0;
          div_d   = (step_div == '0) ? DIV_W'(1)
                                     : step_div;
          leds_d  = (mode == 2'd1) ? MSB1
                  : (mode == 2'd3) ? ONES
                  : LSB1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          leds_d  = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == div_q - DIV_W'(1)) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          leds_d = step_pat;
          dir_d  = step_dir;
          // reps==0 runs forever, so the count is only kept
          // when it can terminate the run.
          if (pass_end && reps_q != '0) begin
            pass_d = pass_inc;
            if (pass_inc == reps_q) begin
              state_d = IDLE;
              leds_d  = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      leds    <= '0;
      busy    <= 1'b0;
      tick    <= 1'b0;
      done    <= 1'b0;
      cnt_q   <= '0;
      div_q   <= '0;
      reps_q  <= '0;
      pass_q  <= '0;
      mode_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      leds    <= leds_d;
      busy    <= busy_d;
      tick    <= tick_d;
      done    <= done_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      reps_q  <= reps_d;
      pass_q  <= pass_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine: directed and random runs of the LED engine,
// checked every cycle against a closed-form pattern model.
module tb_led_pattern_engine;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] step_div = '0;
  logic [7:0]  reps = '0;
  logic [7:0]  leds;
  logic        busy, tick, done;

  int  n_pass = 0;
  int  n_tot = 0;
  bit  chk_en = 1'b0;

  bit        m_run = 1'b0;
  int        m_mode = 0;
  int        m_div = 1;
  int        m_reps = 0;
  int        m_el = 0;
  logic [7:0] e_leds = '0;
  logic      e_busy = 1'b0;
  logic      e_tick = 1'b0;
  logic      e_done = 1'b0;

  led_pattern_engine dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .mode(mode), .step_div(step_div), .reps(reps),
    .leds(leds), .busy(busy), .tick(tick), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int per_pass(int md);
    case (md)
      0, 1:    return N;
      2:       return 2 * N - 2;
      default: return 2;
    endcase
  endfunction

  // Pattern shown after k steps from the initial pattern.
  function automatic logic [7:0] pat(int md, int k);
    int p;
    case (md)
      0: pat = 8'(1 << (k % N));
      1: pat = 8'(128 >> (k % N));
      2: begin
        p   = k % (2 * N - 2);
        pat = 8'(1 << ((p < N) ? p : (2 * N - 2 - p)));
      end
      default: pat = ((k % 2) == 0) ? 8'hFF : 8'h00;
    endcase
  endfunction

  // Model: elapsed clocks since load give the step index directly.
  always @(posedge clk) begin
    e_tick <= 1'b0;
    e_done <= 1'b0;
    if (reset) begin
      m_run  <= 1'b0;
      e_leds <= '0;
      e_busy <= 1'b0;
    end else if (!m_run) begin
      if (start) begin
        m_run  <= 1'b1;
        m_mode <= int'(mode);
        m_div  <= (step_div == 0) ? 1 : int'(step_div);
        m_reps <= int'(reps);
        m_el   <= 0;
        e_leds <= pat(int'(mode), 0);
        e_busy <= 1'b1;
      end
    end else if (stop) begin
      m_run  <= 1'b0;
      e_leds <= '0;
      e_busy <= 1'b0;
    end else begin
      m_el <= m_el + 1;
      if (((m_el + 1) % m_div) == 0) begin
        e_tick <= 1'b1;
        if (m_reps != 0 &&
            (m_el + 1) / m_div == m_reps * per_pass(m_mode)) begin
          m_run  <= 1'b0;
          e_leds <= '0;
          e_busy <= 1'b0;
          e_done <= 1'b1;
        end else begin
          e_leds <= pat(m_mode, (m_el + 1) / m_div);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // One clock; DUT compared against the model at the falling edge.
  task automatic cyc();
    @(negedge clk);
    if (chk_en) begin
      chk("leds", 32'(leds), 32'(e_leds));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("tick", 32'(tick), 32'(e_tick));
      chk("done", 32'(done), 32'(e_done));
    end
  endtask

  task automatic go(input logic [1:0] md, input int dv, input int rp);
    mode     = md;
    step_div = 24'(dv);
    reps     = 8'(rp);
    start    = 1'b1;
    cyc();
    start    = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    chk_en = 1'b1;
    cyc();
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // reset mid-run blink
    go(2'd3, 3, 0);
    repeat (7) cyc();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    chk("t1_leds", 32'(e_leds), 32'h0);
    repeat (5) cyc();
    chk("t1_idle", 32'(e_busy), 32'h0);

    // shift-left, div 4, one pass
    go(2'd0, 4, 1);
    chk("t2_init", 32'(e_leds), 32'h01);
    repeat (4) cyc();
    chk("t2_step1", 32'(e_leds), 32'h02);
    chk("t2_tick1", 32'(e_tick), 32'h1);
    repeat (27) cyc();
    chk("t2_nodone", 32'(e_done), 32'h0);
    cyc();
    chk("t2_done", 32'(e_done), 32'h1);
    chk("t2_off", 32'(e_leds), 32'h0);
    cyc();
    chk("t2_pulse", 32'(e_done), 32'h0);

    // bounce, div 1, two passes
    go(2'd2, 1, 2);
    repeat (8) cyc();
    chk("t3_k8", 32'(e_leds), 32'h40);
    repeat (19) cyc();
    chk("t3_nodone", 32'(e_done), 32'h0);
    cyc();
    chk("t3_done", 32'(e_done), 32'h1);
    repeat (2) cyc();

    // blink forever, stopped at a random point
    go(2'd3, 3, 0);
    chk("t4_init", 32'(e_leds), 32'hFF);
    repeat (3) cyc();
    chk("t4_off", 32'(e_leds), 32'h00);
    repeat (3) cyc();
    chk("t4_on", 32'(e_leds), 32'hFF);
    repeat ($urandom_range(30)) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t4_stop", 32'(e_leds), 32'h0);
    chk("t4_nodone", 32'(e_done), 32'h0);
    repeat (3) cyc();

    // shift-right, div 0, three passes, start mid-run ignored
    go(2'd1, 0, 3);
    chk("t5_init", 32'(e_leds), 32'h80);
    cyc();
    chk("t5_k1", 32'(e_leds), 32'h40);
    repeat (3) cyc();
    start = 1'b1;
    mode  = 2'd0;
    cyc();
    start = 1'b0;
    repeat (18) cyc();
    chk("t5_nodone", 32'(e_done), 32'h0);
    cyc();
    chk("t5_done", 32'(e_done), 32'h1);
    repeat (2) cyc();

    // stop coincident with the final step
    go(2'd0, 4, 1);
    repeat (31) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t6_leds", 32'(e_leds), 32'h0);
    chk("t6_done", 32'(e_done), 32'h0);
    chk("t6_tick", 32'(e_tick), 32'h0);
    chk("t6_busy", 32'(e_busy), 32'h0);
    repeat (2) cyc();

    // random runs
    repeat (40) begin
      stop = ($urandom_range(3) == 0);
      go(2'($urandom), $urandom_range(5), $urandom_range(3));
      stop = 1'b0;
      for (int c = 0; c < 300 && m_run; c++) begin
        start    = ($urandom_range(7) == 0);
        mode     = 2'($urandom);
        step_div = 24'($urandom);
        reps     = 8'($urandom);
        reset    = ($urandom_range(255) == 0);
        stop     = ($urandom_range(63) == 0) ||
                   (m_reps == 0 && c > 50);
        cyc();
      end
      start = 1'b0;
      stop  = 1'b0;
      reset = 1'b0;
      chk("run_bound", 32'(m_run), 32'h0);
      repeat ($urandom_range(3)) cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
